// File: rtl/fault_mem_cfg_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fault_mem_cfg_if : access bus and fault-config bundle             |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface fault_mem_cfg_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  localparam int FB_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic                  write_read;
  logic [ADDR_WIDTH-1:0] address;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic [2:0]            fault_mode;
  logic [ADDR_WIDTH-1:0] fault_addr;
  logic [FB_W-1:0]       fault_bit;
  logic [ADDR_WIDTH-1:0] aggr_addr;
  logic                  fault_hit;

  modport master (
    output write_read, address, wdata, fault_mode, fault_addr, fault_bit, aggr_addr,
    input  rdata, fault_hit
  );

  modport slave (
    input  write_read, address, wdata, fault_mode, fault_addr, fault_bit, aggr_addr,
    output rdata, fault_hit
  );
endinterface
`default_nettype wire

// File: rtl/fault_mem_cfg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | fault_mem_cfg : single-port memory with runtime fault injection   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module fault_mem_cfg #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int CAPACITY   = 16
) (
  input  wire logic       clk,
  input  wire logic       rst,
  fault_mem_cfg_if.slave  bus
);
  localparam int         C_DEPTH      = 1 << ADDR_WIDTH;
  localparam logic [2:0] C_MODE_SA0   = 3'd1;
  localparam logic [2:0] C_MODE_SA1   = 3'd2;
  localparam logic [2:0] C_MODE_TF_UP = 3'd3;
  localparam logic [2:0] C_MODE_TF_DN = 3'd4;
  localparam logic [2:0] C_MODE_CFIN  = 3'd5;
  localparam logic [2:0] C_MODE_NPSF  = 3'd6;
  localparam logic [2:0] C_MODE_RDF   = 3'd7;

  logic [DATA_WIDTH-1:0] r_mem   [C_DEPTH];
  // Fault-free image of every word, needed to judge stuck-at read hits.
  logic [DATA_WIDTH-1:0] r_ideal [C_DEPTH];
  logic [DATA_WIDTH-1:0] r_rdata_s;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_rd_vld;
  logic                  r_fault_hit;

  logic [31:0]           w_bit_idx;
  logic [31:0]           w_addr_idx;
  logic [31:0]           w_vic_idx;
  logic                  w_acc_ok;
  logic                  w_inj;
  logic                  w_is_vic;
  logic                  w_is_aggr;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_cur;
  logic [DATA_WIDTH-1:0] w_vic;
  logic                  w_cur_b;
  logic                  w_wd_b;
  logic                  w_ideal_b;
  logic [ADDR_WIDTH-1:0] w_addr_up;
  logic [ADDR_WIDTH-1:0] w_addr_dn;
  logic                  w_npsf;

  logic [DATA_WIDTH-1:0] w_wr_data;
  logic [DATA_WIDTH-1:0] w_rd_data;
  logic                  w_vic_we;
  logic [DATA_WIDTH-1:0] w_vic_data;
  logic                  w_hit;

  assign w_bit_idx  = 32'(bus.fault_bit);
  assign w_addr_idx = 32'(bus.address);
  assign w_vic_idx  = 32'(bus.fault_addr);
  assign w_acc_ok   = w_addr_idx < CAPACITY;
  assign w_inj      = (w_bit_idx < DATA_WIDTH) && (w_vic_idx < CAPACITY);
  assign w_is_vic   = w_inj && w_acc_ok && (bus.address == bus.fault_addr);
  assign w_is_aggr  = w_inj && w_acc_ok && (bus.address == bus.aggr_addr)
                      && (bus.aggr_addr != bus.fault_addr);

  assign w_mask     = DATA_WIDTH'(1) << bus.fault_bit;
  assign w_cur      = r_mem[bus.address];
  assign w_vic      = r_mem[bus.fault_addr];
  assign w_cur_b    = |(w_cur & w_mask);
  assign w_wd_b     = |(bus.wdata & w_mask);
  assign w_ideal_b  = |(r_ideal[bus.address] & w_mask);

  // Same-word neighbours fall off the ends of the shifted mask, so they read as 0.
  assign w_addr_up  = bus.fault_addr + ADDR_WIDTH'(1);
  assign w_addr_dn  = bus.fault_addr - ADDR_WIDTH'(1);
  assign w_npsf     = ((w_vic_idx + 32'd1) < CAPACITY) && |(r_mem[w_addr_up] & w_mask)
                      && (w_vic_idx != 32'd0) && |(r_mem[w_addr_dn] & w_mask)
                      && |(w_vic & (w_mask << 1))
                      && |(w_vic & (w_mask >> 1));

  always_comb begin
    w_wr_data  = bus.wdata;
    w_rd_data  = '0;
    w_vic_we   = 1'b0;
    w_vic_data = w_vic;
    w_hit      = 1'b0;
    if (w_acc_ok) begin
      if (bus.write_read) begin
        case (bus.fault_mode)
          C_MODE_SA0: if (w_is_vic) begin
            w_wr_data = bus.wdata & ~w_mask;
            w_hit     = w_wd_b;
          end
          C_MODE_SA1: if (w_is_vic) begin
            w_wr_data = bus.wdata | w_mask;
            w_hit     = !w_wd_b;
          end
          C_MODE_TF_UP: if (w_is_vic && !w_cur_b && w_wd_b) begin
            w_wr_data = bus.wdata & ~w_mask;
            w_hit     = 1'b1;
          end
          C_MODE_TF_DN: if (w_is_vic && w_cur_b && !w_wd_b) begin
            w_wr_data = bus.wdata | w_mask;
            w_hit     = 1'b1;
          end
          C_MODE_CFIN: if (w_is_aggr && !w_cur_b && w_wd_b) begin
            w_vic_we   = 1'b1;
            w_vic_data = w_vic ^ w_mask;
            w_hit      = 1'b1;
          end
          C_MODE_NPSF: if (w_is_vic && w_npsf) begin
            w_wr_data = bus.wdata & ~w_mask;
            w_hit     = w_wd_b;
          end
          default: ;
        endcase
      end else begin
        w_rd_data = w_cur;
        case (bus.fault_mode)
          C_MODE_SA0: if (w_is_vic) begin
            w_rd_data = w_cur & ~w_mask;
            w_hit     = w_ideal_b;
          end
          C_MODE_SA1: if (w_is_vic) begin
            w_rd_data = w_cur | w_mask;
            w_hit     = !w_ideal_b;
          end
          C_MODE_RDF: if (w_is_vic) begin
            w_vic_we   = 1'b1;
            w_vic_data = w_vic ^ w_mask;
            w_hit      = 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (bus.write_read && w_acc_ok) begin
      r_mem[bus.address]   <= w_wr_data;
      r_ideal[bus.address] <= bus.wdata;
    end
    if (w_vic_we) begin
      r_mem[bus.fault_addr] <= w_vic_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rdata_s   <= '0;
      r_rdata     <= '0;
      r_rd_vld    <= 1'b0;
      r_fault_hit <= 1'b0;
    end else begin
      r_fault_hit <= w_hit;
      r_rd_vld    <= !bus.write_read;
      if (!bus.write_read) begin
        r_rdata_s <= w_rd_data;
      end
      if (r_rd_vld) begin
        r_rdata <= r_rdata_s;
      end
    end
  end

  assign bus.rdata     = r_rdata;
  assign bus.fault_hit = r_fault_hit;
endmodule
`default_nettype wire

// File: tb/tb_fault_mem_cfg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_fault_mem_cfg : directed + random bench against a word model   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_fault_mem_cfg;
  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int CAP = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fault_mem_cfg_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  fault_mem_cfg #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CAPACITY(CAP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] m_mem   [CAP];
  logic [DW-1:0] m_ideal [CAP];
  logic [DW-1:0] m_rs    = '0;
  logic [DW-1:0] m_rdata = '0;
  bit            m_prev_rd = 1'b0;
  bit            m_hit     = 1'b0;

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit nb(input int a, input int b);
    if (a < 0 || a >= CAP || b < 0 || b >= DW) return 1'b0;
    return m_mem[a][b];
  endfunction

  task automatic model_reset();
    m_rs = '0; m_rdata = '0; m_prev_rd = 1'b0; m_hit = 1'b0;
  endtask

  // Predict the effect of the coming rising edge from the currently driven inputs.
  task automatic model_edge();
    int mode, v, b, ag, a;
    bit en, hit;
    logic [DW-1:0] st, old, nrs;
    mode = int'(bus.fault_mode); v = int'(bus.fault_addr); b = int'(bus.fault_bit);
    ag = int'(bus.aggr_addr);    a = int'(bus.address);
    en  = (b < DW) && (v < CAP);
    hit = 1'b0;
    if (m_prev_rd) m_rdata = m_rs;
    if (bus.write_read) begin
      if (a < CAP) begin
        st  = bus.wdata;
        old = m_mem[a];
        if (en && a == v) begin
          case (mode)
            1: begin st[b] = 1'b0; hit = bus.wdata[b]; end
            2: begin st[b] = 1'b1; hit = !bus.wdata[b]; end
            3: if (!old[b] && bus.wdata[b]) begin st[b] = 1'b0; hit = 1'b1; end
            4: if (old[b] && !bus.wdata[b]) begin st[b] = 1'b1; hit = 1'b1; end
            6: if (nb(v+1, b) && nb(v-1, b) && nb(v, b+1) && nb(v, b-1)) begin
                 st[b] = 1'b0; hit = bus.wdata[b];
               end
            default: ;
          endcase
        end
        if (en && mode == 5 && a == ag && ag != v && !old[b] && bus.wdata[b]) begin
          m_mem[v][b] = ~m_mem[v][b];
          hit = 1'b1;
        end
        m_mem[a]   = st;
        m_ideal[a] = bus.wdata;
      end
    end else begin
      nrs = '0;
      if (a < CAP) begin
        nrs = m_mem[a];
        if (en && a == v) begin
          case (mode)
            1: begin nrs[b] = 1'b0; hit = m_ideal[a][b]; end
            2: begin nrs[b] = 1'b1; hit = !m_ideal[a][b]; end
            7: begin m_mem[a][b] = ~m_mem[a][b]; hit = 1'b1; end
            default: ;
          endcase
        end
      end
      m_rs = nrs;
    end
    m_prev_rd = !bus.write_read;
    m_hit     = hit;
  endtask

  // Called at a falling edge; returns at the next falling edge after checking.
  task automatic op(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.write_read = wr; bus.address = a; bus.wdata = d;
    model_edge();
    @(negedge clk);
    chk_val("rdata", 32'(bus.rdata), 32'(m_rdata));
    chk_val("fault_hit", 32'(bus.fault_hit), 32'(m_hit));
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    op(1'b1, a, d);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    op(1'b0, a, '0);
  endtask

  task automatic cfg(input logic [2:0] m, input logic [AW-1:0] v, input logic [2:0] b,
                     input logic [AW-1:0] ag);
    bus.fault_mode = m; bus.fault_addr = v; bus.fault_bit = b; bus.aggr_addr = ag;
  endtask

  initial begin
    logic [AW-1:0] v, ag, a;
    rst = 1'b1;
    bus.write_read = 1'b0; bus.address = '0; bus.wdata = '0;
    cfg(3'd0, '0, 3'd0, '0);
    repeat (2) @(negedge clk);
    chk_val("reset_rdata", 32'(bus.rdata), 32'h0);
    chk_val("reset_hit", 32'(bus.fault_hit), 32'h0);
    rst = 1'b0;
    model_reset();

    for (int i = 0; i < CAP; i++) wr(AW'(i), DW'($urandom));

    // Ideal memory and two-edge read latency
    wr(4'd3, 8'hA5);
    rd(4'd3);
    rd(4'd3);
    chk_val("t1_latency", 32'(bus.rdata), 32'hA5);

    // Stuck-at-0
    cfg(3'd1, 4'd5, 3'd2, 4'd0);
    wr(4'd5, 8'hFF);
    chk_val("t2_sa0_whit", 32'(bus.fault_hit), 32'h1);
    rd(4'd5);
    chk_val("t2_sa0_rhit", 32'(bus.fault_hit), 32'h1);
    rd(4'd5);
    chk_val("t2_sa0_data", 32'(bus.rdata), 32'hFB);
    wr(4'd5, 8'h00);
    rd(4'd5);
    rd(4'd5);
    chk_val("t2_sa0_zero", 32'(bus.rdata), 32'h00);
    chk_val("t2_sa0_nohit", 32'(bus.fault_hit), 32'h0);

    // Transition faults
    cfg(3'd3, 4'd7, 3'd0, 4'd0);
    wr(4'd7, 8'h00);
    wr(4'd7, 8'h01);
    chk_val("t3_tfup_hit", 32'(bus.fault_hit), 32'h1);
    rd(4'd7);
    rd(4'd7);
    chk_val("t3_tfup_data", 32'(bus.rdata), 32'h00);
    cfg(3'd4, 4'd7, 3'd0, 4'd0);
    wr(4'd7, 8'hFF);
    wr(4'd7, 8'hFE);
    chk_val("t3_tfdn_hit", 32'(bus.fault_hit), 32'h1);
    rd(4'd7);
    rd(4'd7);
    chk_val("t3_tfdn_data", 32'(bus.rdata), 32'hFF);

    // Inversion coupling
    cfg(3'd0, 4'd0, 3'd0, 4'd0);
    wr(4'd9, 8'h00);
    wr(4'd2, 8'h00);
    cfg(3'd5, 4'd9, 3'd4, 4'd2);
    wr(4'd2, 8'h10);
    chk_val("t4_cfin_hit", 32'(bus.fault_hit), 32'h1);
    rd(4'd9);
    rd(4'd9);
    chk_val("t4_cfin_vic", 32'(bus.rdata), 32'h10);
    wr(4'd2, 8'h10);
    chk_val("t4_cfin_nohit", 32'(bus.fault_hit), 32'h0);
    rd(4'd9);
    rd(4'd9);
    chk_val("t4_cfin_hold", 32'(bus.rdata), 32'h10);

    // Neighbourhood pattern, interior and edge victim
    cfg(3'd6, 4'd6, 3'd5, 4'd0);
    wr(4'd5, 8'h20);
    wr(4'd7, 8'h20);
    wr(4'd6, 8'h50);
    wr(4'd6, 8'h70);
    chk_val("t5_npsf_hit", 32'(bus.fault_hit), 32'h1);
    rd(4'd6);
    rd(4'd6);
    chk_val("t5_npsf_data", 32'(bus.rdata), 32'h50);
    cfg(3'd6, 4'd0, 3'd5, 4'd0);
    wr(4'd1, 8'h20);
    wr(4'd0, 8'h50);
    wr(4'd0, 8'h70);
    chk_val("t5_npsf_edge_hit", 32'(bus.fault_hit), 32'h0);
    rd(4'd0);
    rd(4'd0);
    chk_val("t5_npsf_edge_data", 32'(bus.rdata), 32'h70);

    // Read-destructive
    cfg(3'd7, 4'd1, 3'd7, 4'd0);
    wr(4'd1, 8'h80);
    rd(4'd1);
    chk_val("t6_rdf_hit", 32'(bus.fault_hit), 32'h1);
    rd(4'd1);
    chk_val("t6_rdf_first", 32'(bus.rdata), 32'h80);
    rd(4'd1);
    chk_val("t6_rdf_second", 32'(bus.rdata), 32'h00);

    // Asynchronous reset with a read in flight
    cfg(3'd0, 4'd0, 3'd0, 4'd0);
    wr(4'd1, 8'h80);
    rd(4'd1);
    rd(4'd1);
    chk_val("t6_rst_pre", 32'(bus.rdata), 32'h80);
    #1 rst = 1'b1;
    #1 chk_val("t6_rst_async", 32'(bus.rdata), 32'h0);
    model_reset();
    #1 rst = 1'b0;
    wr(4'd2, 8'h33);
    chk_val("t6_rst_discard", 32'(bus.rdata), 32'h0);

    // Randomised traffic concentrated around the victim and aggressor
    for (int i = 0; i < 400; i++) begin
      if (i % 8 == 0) begin
        v  = AW'($urandom_range(0, CAP-1));
        ag = AW'($urandom_range(0, CAP-1));
        cfg(3'($urandom_range(0, 7)), v, 3'($urandom_range(0, DW-1)), ag);
      end
      case ($urandom_range(0, 4))
        0:       a = bus.fault_addr;
        1:       a = bus.fault_addr + AW'(1);
        2:       a = bus.fault_addr - AW'(1);
        3:       a = bus.aggr_addr;
        default: a = AW'($urandom);
      endcase
      op(1'($urandom_range(0, 1)), a, DW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/fault_mem_cfg.md
Name: fault_mem_cfg

Overview:
- Behavioural single-port memory model with a runtime-selectable fault injector. It is the device under test for the MBIST controller in fault-coverage runs.
- It generalises the fixed single-address neighbourhood-pattern-sensitive fault memory. Fault type, victim address, victim bit and aggressor address are ports, so one netlist covers all march-test fault classes without regenerating the script.
- It adds a fault_hit observability pulse for the verification bench.

Parameters:
DATA_WIDTH, 8, word width in bits
ADDR_WIDTH, 4, address width
CAPACITY, 16, number of words (must be <= 2**ADDR_WIDTH)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
write_read  input  1  1 = write, 0 = read, sampled every edge
address  input  ADDR_WIDTH  word address
wdata  input  DATA_WIDTH  write data, same cycle as address
rdata  output  DATA_WIDTH  read data, registered
fault_mode  input  3  fault class select, see Behaviour
fault_addr  input  ADDR_WIDTH  victim word address
fault_bit  input  $clog2(DATA_WIDTH)  victim bit index (also aggressor bit for CFin)
aggr_addr  input  ADDR_WIDTH  aggressor word address (CFin only)
fault_hit  output  1  one-cycle pulse when a fault alters stored or read data

Behaviour:
- Reset:
  - rst is asynchronous. It clears rdata, the internal read stage rdata_s and fault_hit to 0.
  - Memory array contents are not reset. The bench initialises the array by writes.
  - A read in flight during reset is discarded.
- Write: write_read=1 at edge N updates mem[address] at edge N, using the fault-modified data defined below.
- Read:
  - write_read=0 at edge N loads rdata_s <= mem[address] (fault-modified).
  - rdata <= rdata_s at edge N+1, so read latency is 2 edges.
  - rdata holds its value on write cycles.
- Out-of-range access (address >= CAPACITY): a write is ignored; a read returns 0. No fault activates.
- Fault config inputs are sampled at every edge with no latching. A change takes effect on the next access.
- Fault modes (v = fault_addr, b = fault_bit, "victim bit" = mem[v][b]):
  - 0 NONE: ideal memory, fault_hit never asserts.
  - 1 SA0: a write to v stores victim bit 0; a read of v returns bit b = 0. fault_hit asserts when the written or read value differs from ideal.
  - 2 SA1: as SA0 with 1.
  - 3 TF_UP: a write to v with stored bit b = 0 and wdata[b] = 1 leaves bit b at 0. fault_hit asserts.
  - 4 TF_DN: a write to v with stored bit b = 1 and wdata[b] = 0 leaves bit b at 1. fault_hit asserts.
  - 5 CFIN: a write to aggr_addr that changes mem[aggr_addr][b] from 0 to 1 also inverts mem[v][b] on the same edge. fault_hit asserts. If aggr_addr == v, the mode behaves as NONE.
  - 6 NPSF:
    - Neighbours are mem[v+1][b], mem[v-1][b], mem[v][b+1] and mem[v][b-1], evaluated on pre-write contents.
    - A neighbour outside 0..CAPACITY-1 or 0..DATA_WIDTH-1 counts as 0.
    - On a write to v with all four neighbours = 1, stored bit b is forced to 0. fault_hit asserts if wdata[b] was 1.
  - 7 RDF (read-destructive): a read of v returns the correct data but inverts the stored bit b on the same edge. fault_hit asserts.
- fault_hit:
  - Registered; high for exactly the cycle after the triggering edge.
  - Asserts only when the fault changes data. A write that already matches the faulty value gives no pulse.
- Fault logic never touches words other than v, except CFIN, which writes both aggr_addr and v.
- fault_bit >= DATA_WIDTH disables injection (NONE behaviour).

Test Plan:
All scenarios use DATA_WIDTH=8, ADDR_WIDTH=4, CAPACITY=16.
1. mode 0: write 0xA5 to addr 3, read addr 3 -> rdata = 0xA5 exactly 2 edges after the read edge; fault_hit stays 0.
2. mode 1, v=5, b=2: write 0xFF to 5, read 5 -> rdata = 0xFB, fault_hit pulses on the write and the read. Write 0x00 to 5, read -> 0x00, no pulse.
3. mode 3, v=7, b=0: write 0x00 then 0x01 to 7, read -> 0x00 with a fault_hit pulse. Switch to mode 4, write 0xFF, then write 0xFE, read -> 0xFF with a fault_hit pulse.
4. mode 5, v=9, aggr=2, b=4: init mem[9]=0x00, mem[2]=0x00. Write 0x10 to 2 -> mem[9] reads 0x10. Write 0x10 to 2 again -> mem[9] is unchanged.
5. mode 6, v=6, b=5:
   - Write 0x20 to 5 and 7, write 0x50 to 6, then write 0x70 to 6 -> read 6 gives 0x50 with a fault_hit pulse.
   - Repeat with v=0 -> no fault, because neighbour v-1 is out of range and counts as 0.
6. mode 7, v=1, b=7: write 0x80 to 1, read twice -> rdata 0x80 then 0x00. Assert rst between a read edge and the rdata edge -> rdata = 0 immediately and stays 0.
